imem_loader: RTL and testbench



---
 rtl/imem_loader.sv | 158 +++++++++++++++
 tb/tb_imem_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory program loader: streams valid/ready beats into imem, freezes the core, drains the pipeline, then releases it.
// Optional feature: define IMEM_CHECKSUM_EN to treat the inLast beat as an XOR checksum trailer.
module imem_loader #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 256,
  parameter int FLUSH_CYCLES = 5
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              start,
  input  logic              inValid,
  input  logic [DATA_W-1:0] inData,
  input  logic              inLast,
  output logic              inReady,
  output logic              memWriteEn,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWriteData,
  output logic              cpuHold,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   wordCount,
  output logic              csErr,
  output logic [2:0]        fsmState
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] FLUSH = 3'd2;
  localparam logic [2:0] RUN   = 3'd3;
  localparam logic [2:0] ERR   = 3'd4;

  localparam int              FW         = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FW-1:0]   FLUSH_LAST = FW'(FLUSH_CYCLES - 1);
  localparam logic [ADDR_W:0] DEPTH_C    = (ADDR_W + 1)'(DEPTH);

  // Handshake: a beat transfers on a rising edge where inValid && inReady; the source holds it otherwise.
  logic [2:0]        state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [FW-1:0]     flush_q, flush_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ovf_q, ovf_d;
  logic [ADDR_W:0]   count_inc;
`ifdef IMEM_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
  logic              cserr_q, cserr_d;
`endif

  assign count_inc = count_q + 1'b1;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    flush_d = flush_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ovf_d   = ovf_q;
`ifdef IMEM_CHECKSUM_EN
    csum_d  = csum_q;
    cserr_d = cserr_q;
`endif
    case (state_q)
      IDLE, RUN, ERR: begin
        if (start) begin
          state_d = LOAD;
          count_d = '0;
          ovf_d   = 1'b0;
`ifdef IMEM_CHECKSUM_EN
          csum_d  = '0;
          cserr_d = 1'b0;
`endif
        end
      end
      LOAD: begin
        if (inValid) begin
`ifdef IMEM_CHECKSUM_EN
          // Trailer beat is compared, never written or counted.
          if (inLast) begin
            if (inData == csum_q) begin
              state_d = FLUSH;
              flush_d = '0;
            end else begin
              cserr_d = 1'b1;
              state_d = ERR;
            end
          end else
`endif
          begin
            we_d    = 1'b1;
            addr_d  = count_q[ADDR_W-1:0];
            wdata_d = inData;
            count_d = count_inc;
`ifdef IMEM_CHECKSUM_EN
            csum_d  = csum_q ^ inData;
`endif
            if (inLast || (count_inc == DEPTH_C)) begin
              ovf_d   = !inLast;
              state_d = FLUSH;
              flush_d = '0;
            end
          end
        end
      end
      FLUSH: begin
        if (flush_q == FLUSH_LAST) state_d = RUN;
        else                       flush_d = flush_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      count_q <= '0;
      flush_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ovf_q   <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
      csum_q  <= '0;
      cserr_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      flush_q <= flush_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ovf_q   <= ovf_d;
`ifdef IMEM_CHECKSUM_EN
      csum_q  <= csum_d;
      cserr_q <= cserr_d;
`endif
    end
  end

  assign inReady      = (state_q == LOAD);
  assign cpuHold      = (state_q != RUN);
  assign done         = (state_q == RUN);
  assign memWriteEn   = we_q;
  assign memAddr      = addr_q;
  assign memWriteData = wdata_q;
  assign overflow     = ovf_q;
  assign wordCount    = count_q;
  assign fsmState     = state_q;
`ifdef IMEM_CHECKSUM_EN
  assign csErr = cserr_q;
`else
  assign csErr = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: full-depth instance plus a DEPTH=4 instance for overflow.
// Build with IMEM_CHECKSUM_EN defined to exercise the checksum trailer path instead of the plain loads.
module tb_imem_loader;

  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_ERR  = 3'd4;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        start = 1'b0, inValid = 1'b0, inLast = 1'b0;
  logic [31:0] inData = '0;
  logic        inReady, memWriteEn, cpuHold, done, overflow, csErr;
  logic [7:0]  memAddr;
  logic [31:0] memWriteData;
  logic [8:0]  wordCount;
  logic [2:0]  fsmState;

  logic        s_start = 1'b0, s_valid = 1'b0, s_last = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready, s_we, s_hold, s_done, s_ovf, s_cserr;
  logic [7:0]  s_addr;
  logic [31:0] s_wdata;
  logic [8:0]  s_count;
  logic [2:0]  s_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [39:0] exp_q[$];
  logic [39:0] exp_s_q[$];
  logic [31:0] prog [4] = '{32'h20010005, 32'h20020003, 32'h00221820, 32'hAC030000};

  always #5 Clk = ~Clk;

  imem_loader dut (
    .Clk(Clk), .Rst(Rst), .start(start), .inValid(inValid), .inData(inData), .inLast(inLast),
    .inReady(inReady), .memWriteEn(memWriteEn), .memAddr(memAddr), .memWriteData(memWriteData),
    .cpuHold(cpuHold), .done(done), .overflow(overflow), .wordCount(wordCount), .csErr(csErr),
    .fsmState(fsmState)
  );

  imem_loader #(.DEPTH(4)) dut_small (
    .Clk(Clk), .Rst(Rst), .start(s_start), .inValid(s_valid), .inData(s_data), .inLast(s_last),
    .inReady(s_ready), .memWriteEn(s_we), .memAddr(s_addr), .memWriteData(s_wdata),
    .cpuHold(s_hold), .done(s_done), .overflow(s_ovf), .wordCount(s_count), .csErr(s_cserr),
    .fsmState(s_state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Offer one beat and hold it until the edge that accepts it.
  task automatic send(input logic [31:0] d, input logic last);
    int budget;
    inValid = 1'b1;
    inData  = d;
    inLast  = last;
    budget  = 0;
    while (!inReady && budget < 20) begin
      tick();
      budget++;
    end
    check("beat_accept_timeout", 64'(budget < 20), 1);
    tick();
    inValid = 1'b0;
    inLast  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic expect_prog();
    for (int i = 0; i < 4; i++) exp_q.push_back({8'(i), prog[i]});
  endtask

  // Called right after the last acceptance edge: done must rise exactly FLUSH_CYCLES edges later.
  task automatic check_flush(input string tag, input logic [8:0] words);
    check({tag, "_wordcount"}, 64'(wordCount), 64'(words));
    check({tag, "_inready_off"}, 64'(inReady), 0);
    for (int k = 1; k < 5; k++) tick();
    check({tag, "_done_early"}, 64'({done, cpuHold}), 64'(2'b01));
    tick();
    check({tag, "_done"}, 64'({done, cpuHold}), 64'(2'b10));
  endtask

  always @(negedge Clk) begin
    if (!Rst && memWriteEn) begin
      check("write_expected", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("write_addr_data", 64'({memAddr, memWriteData}), 64'(exp_q.pop_front()));
    end
    if (!Rst && s_we) begin
      check("small_write_expected", 64'(exp_s_q.size() != 0), 1);
      if (exp_s_q.size() != 0) check("small_write", 64'({s_addr, s_wdata}), 64'(exp_s_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    logic rdy;
    repeat (2) tick();
    check("rst_hold_ready", 64'({cpuHold, inReady}), 64'(2'b10));
    check("rst_write", 64'({memWriteEn, memAddr, memWriteData}), 0);
    check("rst_flags", 64'({done, overflow, csErr}), 0);
    check("rst_wordcount", 64'(wordCount), 0);
    Rst = 1'b0;
    tick();
    check("idle_hold", 64'({cpuHold, inReady, done}), 64'(3'b100));

`ifndef IMEM_CHECKSUM_EN
    // Continuous stream.
    pulse_start();
    check("load_ready", 64'(inReady), 1);
    expect_prog();
    for (int i = 0; i < 4; i++) send(prog[i], i == 3);
    check_flush("cont", 9'd4);
    check("cont_ovf", 64'(overflow), 0);

    // Restart from RUN, then a gapped stream.
    pulse_start();
    check("rerun_state", 64'({done, cpuHold, inReady}), 64'(3'b011));
    check("rerun_wordcount", 64'(wordCount), 0);
    expect_prog();
    for (int i = 0; i < 4; i++) begin
      send(prog[i], i == 3);
      if (i != 3) tick();
    end
    check_flush("gap", 9'd4);

    // Overflow on the DEPTH=4 instance: 6 beats offered, no inLast.
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int i = 0; i < 4; i++) exp_s_q.push_back({8'(i), 32'h100 + 32'(i)});
    acc = 0;
    s_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      s_data = 32'h100 + 32'(acc);
      rdy = s_ready;
      tick();
      if (rdy) acc++;
    end
    s_valid = 1'b0;
    check("ovf_accepted", 64'(acc), 4);
    check("ovf_flag", 64'({s_ovf, s_ready}), 64'(2'b10));
    check("ovf_wordcount", 64'(s_count), 4);
    acc = 0;
    while (!s_done && acc < 10) begin
      tick();
      acc++;
    end
    check("ovf_run", 64'({s_done, s_hold}), 64'(2'b10));

    // Async reset in the middle of a load.
    pulse_start();
    exp_q.push_back({8'd0, prog[0]});
    exp_q.push_back({8'd1, prog[1]});
    send(prog[0], 1'b0);
    send(prog[1], 1'b0);
    tick();
    check("mid_wordcount", 64'(wordCount), 2);
    Rst = 1'b1;
    #1;
    check("arst_hold_ready", 64'({cpuHold, inReady, done}), 64'(3'b100));
    check("arst_write", 64'({memWriteEn, memAddr, memWriteData}), 0);
    check("arst_wordcount", 64'(wordCount), 0);
    tick();
    Rst = 1'b0;
    tick();
    pulse_start();
    expect_prog();
    for (int i = 0; i < 4; i++) send(prog[i], i == 3);
    check_flush("reload", 9'd4);
`else
    // Good trailer: 1^2^4 = 7.
    pulse_start();
    exp_q.push_back({8'd0, 32'h1});
    exp_q.push_back({8'd1, 32'h2});
    exp_q.push_back({8'd2, 32'h4});
    send(32'h1, 1'b0);
    send(32'h2, 1'b0);
    send(32'h4, 1'b0);
    send(32'h7, 1'b1);
    check_flush("cs_ok", 9'd3);
    check("cs_ok_err", 64'(csErr), 0);

    // Bad trailer.
    pulse_start();
    exp_q.push_back({8'd0, 32'h1});
    exp_q.push_back({8'd1, 32'h2});
    exp_q.push_back({8'd2, 32'h4});
    send(32'h1, 1'b0);
    send(32'h2, 1'b0);
    send(32'h4, 1'b0);
    send(32'h6, 1'b1);
    check("cs_bad_err", 64'(csErr), 1);
    check("cs_bad_state", 64'(fsmState), 64'(ST_ERR));
    check("cs_bad_outs", 64'({cpuHold, done, inReady}), 64'(3'b100));
    repeat (3) tick();
    check("cs_err_sticky", 64'({fsmState, csErr}), 64'({ST_ERR, 1'b1}));
    pulse_start();
    check("cs_err_clear", 64'({fsmState, csErr}), 64'({ST_LOAD, 1'b0}));
`endif

    repeat (3) tick();
    check("exp_q_drained", 64'(exp_q.size()), 0);
    check("exp_s_q_drained", 64'(exp_s_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
